// File: rtl/packet_rx.sv
// RMII receive parser: preamble/SFD lock, MAC/length filter, fixed-size payload
// streamed as AXI-Stream words, CRC-32 FCS check reported on the tlast beat.

module crc_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [1:0]  din,
  output logic [31:0] crc
);
  function automatic logic [31:0] step(input logic [31:0] c, input logic b);
    step = (c[0] ^ b) ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
  endfunction

  // Reflected CRC-32, bit 0 of each dibit is first on the wire
  always_ff @(posedge clk) begin
    if (rst || clr) crc <= 32'hFFFF_FFFF;
    else if (en)    crc <= step(step(crc, din[0]), din[1]);
  end
endmodule

// state    | meaning
// IDLE     | armed, waiting for the first preamble dibit
// PREAMBLE | 01 dibits, 11 marks the SFD tail
// HEADER   | 56 dibits shifted in, destination and length checked on the last
// DATA     | payload dibits, one word per 16 dibits, last word parked
// FCS      | 16 FCS dibits captured, then compared with the running CRC
// DROP     | discard until carrier drops
module packet_rx #(
  parameter logic [47:0] LOCAL_MAC            = 48'h00_18_3E_01_EB_6E,
  parameter int          MII_WIDTH            = 2,
  parameter int          PACKET_PAYLOAD_WORDS = 64,
  parameter int          WORD_BYTES           = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    crs_dv,
  input  logic [MII_WIDTH-1:0]    rxd,
  output logic [WORD_BYTES*8-1:0] m_axis_tdata,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tuser,
  input  logic                    m_axis_tready,
  output logic                    frame_good,
  output logic                    frame_err
);
  localparam int WORD_W      = WORD_BYTES * 8;
  localparam int WORD_DIBITS = WORD_BYTES * 4;
  localparam int WB          = $clog2(WORD_DIBITS);
  localparam int DATA_DIBITS = PACKET_PAYLOAD_WORDS * WORD_BYTES * 4;
  localparam int CNT_W       = $clog2(DATA_DIBITS) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_HEADER, S_DATA, S_FCS, S_DROP
  } state_t;

  state_t state, state_n;
  logic [CNT_W-1:0] cnt;

  logic                 crs_q;
  logic [MII_WIDTH-1:0] rxd_q;
  logic [111:0]         hdr, hdr_n;
  logic [WORD_W-1:0]    sh, word_n, parked, last_data, out_data;
  logic [31:0]          fcs_rx, fcs_n, crc;
  logic [47:0]          dest;
  logic [15:0]          len_f;
  logic                 hdr_ok, word_end;
  logic                 ovf, any_beat, pend_last, last_user;
  logic                 out_valid, out_last, out_user, free, word_go, last_go;
  logic                 word_load, word_park, fcs_end, trunc;
  logic                 crc_en, crc_clr;

  assign hdr_n    = {rxd_q, hdr[111:2]};
  assign word_n   = {rxd_q, sh[WORD_W-1:MII_WIDTH]};
  assign fcs_n    = {rxd_q, fcs_rx[31:MII_WIDTH]};
  assign word_end = &cnt[WB-1:0];

  // Wire byte k sits in hdr_n[8k+7:8k]; byte 0 is the MAC's most significant byte
  always_comb begin
    dest = '0;
    for (int i = 0; i < 6; i++) dest[47-8*i -: 8] = hdr_n[8*i +: 8];
    len_f = {hdr_n[103:96], hdr_n[111:104]};
  end

  assign hdr_ok = (dest == LOCAL_MAC || dest == 48'hFFFF_FFFF_FFFF) &&
                  (len_f == 16'(PACKET_PAYLOAD_WORDS * WORD_BYTES));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_DROP;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= (state_n != state) ? '0 : cnt + 1'b1;
    end
  end

  always_comb begin
    state_n   = state;
    word_load = 1'b0;
    word_park = 1'b0;
    fcs_end   = 1'b0;
    trunc     = 1'b0;
    case (state)
      S_IDLE:
        if (crs_q && rxd_q == 2'b01) state_n = S_PREAMBLE;
      S_PREAMBLE:
        if (!crs_q)               state_n = S_IDLE;
        else if (rxd_q == 2'b11)  state_n = S_HEADER;
        else if (rxd_q != 2'b01)  state_n = S_DROP;
      S_HEADER:
        if (!crs_q)                     state_n = S_IDLE;
        else if (cnt == CNT_W'(55))     state_n = hdr_ok ? S_DATA : S_DROP;
      S_DATA:
        if (!crs_q) begin
          trunc   = any_beat;
          state_n = S_IDLE;
        end else if (word_end) begin
          if (cnt == CNT_W'(DATA_DIBITS - 1)) begin
            word_park = 1'b1;
            state_n   = S_FCS;
          end else begin
            word_load = 1'b1;
          end
        end
      S_FCS:
        if (!crs_q) begin
          trunc   = 1'b1;
          state_n = S_IDLE;
        end else if (cnt == CNT_W'(15)) begin
          fcs_end = 1'b1;
          state_n = S_DROP;
        end
      S_DROP:
        if (!crs_q) state_n = S_IDLE;
      default: state_n = S_DROP;
    endcase
  end

  assign crc_en  = crs_q && (state == S_HEADER || state == S_DATA);
  assign crc_clr = (state == S_IDLE);

  crc_gen u_crc (
    .clk (clk),
    .rst (rst),
    .clr (crc_clr),
    .en  (crc_en),
    .din (rxd_q),
    .crc (crc)
  );

  // A pending tlast beat blocks new words so the frame end is never reordered
  assign free    = !out_valid || m_axis_tready;
  assign word_go = free && !pend_last;
  assign last_go = free && pend_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      crs_q     <= 1'b0;
      rxd_q     <= '0;
      hdr       <= '0;
      sh        <= '0;
      fcs_rx    <= '0;
      parked    <= '0;
      last_data <= '0;
      last_user <= 1'b0;
      pend_last <= 1'b0;
      ovf       <= 1'b0;
      any_beat  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_user  <= 1'b0;
    end else begin
      crs_q <= crs_dv;
      rxd_q <= rxd;
      if (state == S_HEADER) hdr    <= hdr_n;
      if (state == S_DATA)   sh     <= word_n;
      if (state == S_FCS)    fcs_rx <= fcs_n;
      if (state == S_IDLE) begin
        ovf      <= 1'b0;
        any_beat <= 1'b0;
      end
      if (out_valid && m_axis_tready) out_valid <= 1'b0;
      if (word_load) begin
        if (word_go) begin
          out_valid <= 1'b1;
          out_data  <= word_n;
          out_last  <= 1'b0;
          out_user  <= 1'b0;
          any_beat  <= 1'b1;
        end else begin
          ovf <= 1'b1;
        end
      end else if (last_go) begin
        out_valid <= 1'b1;
        out_data  <= last_data;
        out_last  <= 1'b1;
        out_user  <= last_user;
        pend_last <= 1'b0;
      end
      if (word_park) parked <= word_n;
      if (fcs_end) begin
        pend_last <= 1'b1;
        last_data <= parked;
        last_user <= (fcs_n != ~crc) || ovf;
      end
      if (trunc) begin
        pend_last <= 1'b1;
        last_data <= '0;
        last_user <= 1'b1;
      end
    end
  end

  assign m_axis_tdata  = out_data;
  assign m_axis_tvalid = out_valid;
  assign m_axis_tlast  = out_last;
  assign m_axis_tuser  = out_user;
  assign frame_good    = out_valid && m_axis_tready && out_last && !out_user;
  assign frame_err     = out_valid && m_axis_tready && out_last && out_user;
endmodule
